regbank_wr_arbiter: RTL and testbench

- Write-port arbiter and sequencer for a bank of NREG 4-bit load-enable registers (d/clk/ld/rst/q style).
- Two requesters share the bank's single write data bus. The block arbitrates between them round-robin, drives a one-hot per-register ld vector and the shared d bus, and returns a one-cycle grant pulse.
- Sits between the control FSMs and the register bank. The bank's q outputs are read directly and do not pass through this block.

---
 rtl/regbank_wr_arbiter.sv | 115 +++++++++++
 tb/tb_regbank_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write-port arbiter for a bank of NREG load-enable registers.
// Two requesters share the d bus; every output is registered.
module regbank_wr_arbiter #(
    parameter int DW   = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic [AW-1:0]   addr0,
    input  logic [DW-1:0]   data0,
    input  logic            req1,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   data1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [NREG-1:0] ld,
    output logic [DW-1:0]   d,
    output logic            last
);

    // One-hot decode of a register index into a load-enable vector.
    function automatic logic [NREG-1:0] addr_decode(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = {NREG{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

    logic            gnt0_r;
    logic            gnt1_r;
    logic [NREG-1:0] ld_r;
    logic [DW-1:0]   d_r;
    logic            last_r;

    logic            elig0_s;
    logic            elig1_s;
    logic            win_valid_s;
    logic            win_sel_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_data_s;

    // A requester whose grant is currently high is held off for one cycle,
    // so a level request not yet dropped cannot be written twice.
    assign elig0_s = req0 & ~gnt0_r;
    assign elig1_s = req1 & ~gnt1_r;

    // Arbitration: single eligible requester wins, a tie goes to the one that did not win last.
    always_comb begin
        win_valid_s = 1'b0;
        win_sel_s   = 1'b0;
        case ({elig1_s, elig0_s})
            2'b01: begin
                win_valid_s = 1'b1;
                win_sel_s   = 1'b0;
            end
            2'b10: begin
                win_valid_s = 1'b1;
                win_sel_s   = 1'b1;
            end
            2'b11: begin
                win_valid_s = 1'b1;
                win_sel_s   = ~last_r;
            end
            default: begin
                win_valid_s = 1'b0;
                win_sel_s   = 1'b0;
            end
        endcase
    end

    // Address and data mux for the selected requester.
    always_comb begin
        win_addr_s = {AW{1'b0}};
        win_data_s = {DW{1'b0}};
        if (win_sel_s) begin
            win_addr_s = addr1;
            win_data_s = data1;
        end else begin
            win_addr_s = addr0;
            win_data_s = data0;
        end
    end

    // Output registers and round-robin state; reset leaves last=1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            ld_r   <= {NREG{1'b0}};
            d_r    <= {DW{1'b0}};
            last_r <= 1'b1;
        end else if (win_valid_s) begin
            gnt0_r <= ~win_sel_s;
            gnt1_r <= win_sel_s;
            ld_r   <= addr_decode(win_addr_s);
            d_r    <= win_data_s;
            last_r <= win_sel_s;
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            ld_r   <= {NREG{1'b0}};
            d_r    <= d_r;
            last_r <= last_r;
        end
    end

    assign gnt0 = gnt0_r;
    assign gnt1 = gnt1_r;
    assign ld   = ld_r;
    assign d    = d_r;
    assign last = last_r;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: priority-rotation model checked every cycle,
// a resettable register bank fed by ld/d, and directed hand-computed checks.
module tb_regbank_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [1:0] addr0, addr1;
    logic [3:0] data0, data1;
    logic       gnt0, gnt1, last;
    logic [3:0] ld, d;

    int checks = 0;
    int errors = 0;

    regbank_wr_arbiter #(.DW(4), .NREG(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .ld(ld), .d(d), .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = first eligible requester in priority order starting after the last winner.
    function automatic int pick_winner(input bit e0, input bit e1, input bit lst);
        bit elig [2];
        int cand;
        elig[0] = e0;
        elig[1] = e1;
        for (int k = 0; k < 2; k++) begin
            cand = (int'(lst) + 1 + k) % 2;
            if (elig[cand]) return cand;
        end
        return -1;
    endfunction

    logic       m_valid = 1'b0;
    logic       m_gnt0, m_gnt1, m_last;
    logic [3:0] m_ld, m_d;
    int         m_win;
    logic [3:0] bank [4];

    always_comb m_win = pick_winner(req0 && !m_gnt0, req1 && !m_gnt1, m_last);

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (rst) begin
            m_gnt0 <= 1'b0;
            m_gnt1 <= 1'b0;
            m_ld   <= 4'b0000;
            m_d    <= 4'b0000;
            m_last <= 1'b1;
        end else begin
            m_gnt0 <= (m_win == 0);
            m_gnt1 <= (m_win == 1);
            if (m_win >= 0) begin
                m_ld   <= 4'b0001 << ((m_win == 0) ? addr0 : addr1);
                m_d    <= (m_win == 0) ? data0 : data1;
                m_last <= m_win[0];
            end else begin
                m_ld <= 4'b0000;
            end
        end
    end

    // Register bank driven by the arbiter; its own reset wins over a load.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) bank[i] <= 4'b0000;
            else if (ld[i]) bank[i] <= d;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_gnt0", gnt0, m_gnt0);
            chk("cmp_gnt1", gnt1, m_gnt1);
            chk("cmp_ld", ld, m_ld);
            chk("cmp_d", d, m_d);
            chk("cmp_last", last, m_last);
            chk("inv_ld_onehot", ($countones(ld) <= 1), 1);
            chk("inv_gnt_excl", (gnt0 && gnt1), 0);
        end
    end

    // Drop each request on seeing its grant; report grant order and ld at each grant.
    task automatic serve(output int first, output int second,
                         output logic [3:0] ld_first, output logic [3:0] ld_second);
        first = -1; second = -1; ld_first = 4'b0000; ld_second = 4'b0000;
        for (int c = 0; c < 20 && (req0 || req1); c++) begin
            @(negedge clk);
            if (gnt0) begin
                if (first < 0) begin first = 0; ld_first = ld; end
                else begin second = 0; ld_second = ld; end
                req0 = 1'b0;
            end
            if (gnt1) begin
                if (first < 0) begin first = 1; ld_first = ld; end
                else begin second = 1; ld_second = ld; end
                req1 = 1'b0;
            end
        end
        chk("serve_timeout", (req0 || req1), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, s;
        logic [3:0] lf, ls;
        bit [5:0] pat;

        // Reset held two cycles with both requests up.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        addr0 = 2'd0; data0 = 4'h7; addr1 = 2'd1; data1 = 4'h8;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_ld", ld, 4'b0000);
        chk("rst_d", d, 4'b0000);
        chk("rst_last", last, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt0", gnt0, 1);
        chk("post_rst_ld", ld, 4'b0001);
        chk("post_rst_d", d, 4'h7);
        req0 = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt1", gnt1, 1);
        chk("post_rst_ld1", ld, 4'b0010);
        req1 = 1'b0;
        @(negedge clk);

        // Single write to reg2.
        req0 = 1'b1; addr0 = 2'd2; data0 = 4'b0110;
        serve(f, s, lf, ls);
        chk("single_first", f, 0);
        chk("single_ld", lf, 4'b0100);
        @(negedge clk);
        chk("single_gnt_gone", gnt0, 0);
        chk("single_ld_gone", ld, 4'b0000);
        chk("single_bank2", bank[2], 4'b0110);

        // Held request: req1 alone for six cycles.
        req1 = 1'b1; addr1 = 2'd1; data1 = 4'b1111;
        pat = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk("held_gnt1", gnt1, pat[i]);
            chk("held_ld", ld, pat[i] ? 4'b0010 : 4'b0000);
        end
        req1 = 1'b0;
        @(negedge clk);

        // Contention with last=1: requester 0 first.
        req0 = 1'b1; addr0 = 2'd1; data0 = 4'b0011;
        req1 = 1'b1; addr1 = 2'd3; data1 = 4'b1010;
        serve(f, s, lf, ls);
        chk("cont_first", f, 0);
        chk("cont_second", s, 1);
        chk("cont_ld_first", lf, 4'b0010);
        chk("cont_ld_second", ls, 4'b1000);
        @(negedge clk);
        chk("cont_bank1", bank[1], 4'b0011);
        chk("cont_bank3", bank[3], 4'b1010);

        // Make requester 0 the last winner, then both target reg0.
        req0 = 1'b1; addr0 = 2'd2; data0 = 4'b0110;
        serve(f, s, lf, ls);
        @(negedge clk);
        chk("same_pre_last", last, 0);
        req0 = 1'b1; addr0 = 2'd0; data0 = 4'b0101;
        req1 = 1'b1; addr1 = 2'd0; data1 = 4'b1001;
        serve(f, s, lf, ls);
        chk("same_first", f, 1);
        chk("same_second", s, 0);
        @(negedge clk);
        chk("same_bank0", bank[0], 4'b0101);

        // Reset lands in the gnt1 cycle; requester 0 is held across it.
        req1 = 1'b1; addr1 = 2'd2; data1 = 4'b1111;
        @(negedge clk);
        chk("mid_gnt1", gnt1, 1);
        chk("mid_ld", ld, 4'b0100);
        rst = 1'b1; req1 = 1'b0;
        req0 = 1'b1; addr0 = 2'd3; data0 = 4'b1100;
        @(negedge clk);
        chk("mid_rst_gnt1", gnt1, 0);
        chk("mid_rst_ld", ld, 4'b0000);
        chk("mid_rst_bank2", bank[2], 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rearb_gnt0", gnt0, 1);
        chk("mid_rearb_ld", ld, 4'b1000);
        req0 = 1'b0;
        @(negedge clk);
        chk("mid_rearb_bank3", bank[3], 4'b1100);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
